// File: rtl/tm1638_responder_if.sv
// TM1638 serial bus: active-low frame strobe plus split DIO pad (sampled input, drive value, drive enable).
interface tm1638_responder_if;
  logic stb_in;
  logic dio_in;
  logic dio_out;
  logic dio_oe;

  modport master (output stb_in, dio_in, input dio_out, dio_oe);
  modport slave  (input stb_in, dio_in, output dio_out, dio_oe);
endinterface

// File: rtl/tm1638_responder.sv
// Device-side TM1638: deserialises STB-framed command/data bytes, holds display RAM and control, returns key bits.
// Optional protocol error counter enabled by defining TM1638_RESP_ERR_EN.
module tm1638_responder #(
  parameter int RAM_BYTES = 16,
  parameter int KEY_BITS  = 32
) (
  input  logic                     clk_400KHz,
  input  logic                     rst,
  tm1638_responder_if.slave        bus,
  input  logic [KEY_BITS-1:0]      key_in,
  output logic [8*RAM_BYTES-1:0]   disp_ram,
  output logic                     disp_on,
  output logic [2:0]               brightness,
  output logic                     frame_done,
  output logic [7:0]               err_cnt
);
  localparam int AW = $clog2(RAM_BYTES);
  localparam int CW = $clog2(KEY_BITS);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, TURN, KEYTX, IGNORE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]                cnt;
  logic [2:0]                   bit_idx, bit_inc;
  logic [6:0]                   sh;
  logic [7:0]                   byte_val;
  logic [AW-1:0]                addr;
  logic                         fixed, got_byte;
  logic [KEY_BITS-1:0]          snap;
  logic [RAM_BYTES-1:0][7:0]    ram;
  logic                         in_byte_st, byte_end;
  logic                         mode_ld, snap_ld, addr_ld, ctrl_ld, ram_we, err_evt;
  logic                         oe_nxt, out_nxt;

  assign bit_idx    = cnt[2:0];
  assign bit_inc    = bit_idx + 3'd1;
  // The 8th bit is used straight from the pad so the byte decodes on the edge that completes it.
  assign byte_val   = {bus.dio_in, sh};
  assign in_byte_st = (state == CMD) || (state == WDATA) || (state == IGNORE);
  assign byte_end   = !bus.stb_in && in_byte_st && (bit_idx == 3'd7);
  assign disp_ram   = ram;

  always_ff @(posedge clk_400KHz or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mode_ld   = 1'b0;
    snap_ld   = 1'b0;
    addr_ld   = 1'b0;
    ctrl_ld   = 1'b0;
    ram_we    = 1'b0;
    err_evt   = 1'b0;
    oe_nxt    = 1'b0;
    out_nxt   = 1'b1;
    if (bus.stb_in) begin
      state_nxt = IDLE;
      // A key-read abort is a legal early release; only byte-collecting states leave partial bytes.
      err_evt   = in_byte_st && (bit_idx != 3'd0);
    end else begin
      case (state)
        IDLE:  state_nxt = CMD;
        CMD: begin
          if (bit_idx == 3'd7) begin
            case (byte_val[7:6])
              2'b01: begin
                if (byte_val[1:0] == 2'b00) begin
                  mode_ld   = 1'b1;
                  state_nxt = IGNORE;
                end else if (byte_val[1:0] == 2'b10) begin
                  snap_ld   = 1'b1;
                  state_nxt = TURN;
                end else begin
                  err_evt   = 1'b1;
                  state_nxt = IGNORE;
                end
              end
              2'b11: begin
                addr_ld   = 1'b1;
                state_nxt = WDATA;
              end
              2'b10: begin
                ctrl_ld   = 1'b1;
                state_nxt = IGNORE;
              end
              default: begin
                err_evt   = 1'b1;
                state_nxt = IGNORE;
              end
            endcase
          end
        end
        WDATA:  ram_we = (bit_idx == 3'd7);
        TURN:   state_nxt = KEYTX;
        KEYTX: begin
          oe_nxt  = 1'b1;
          out_nxt = snap[cnt];
          if (cnt == CW'(KEY_BITS-1)) state_nxt = IGNORE;
        end
        IGNORE: err_evt = (bit_idx == 3'd7);
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_400KHz or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      sh          <= '0;
      addr        <= '0;
      fixed       <= 1'b0;
      got_byte    <= 1'b0;
      snap        <= '0;
      ram         <= '0;
      disp_on     <= 1'b0;
      brightness  <= '0;
      frame_done  <= 1'b0;
      bus.dio_oe  <= 1'b0;
      bus.dio_out <= 1'b1;
    end else begin
      bus.dio_oe  <= oe_nxt;
      bus.dio_out <= out_nxt;
      frame_done  <= bus.stb_in && got_byte;
      if (bus.stb_in) begin
        cnt      <= '0;
        got_byte <= 1'b0;
      end else begin
        if (byte_end) got_byte <= 1'b1;
        case (state)
          IDLE, CMD, WDATA, IGNORE: cnt <= CW'(bit_inc);
          TURN:                     cnt <= '0;
          KEYTX:                    cnt <= (cnt == CW'(KEY_BITS-1)) ? '0 : cnt + CW'(1);
          default:                  cnt <= '0;
        endcase
        if (in_byte_st || state == IDLE) begin
          for (int i = 0; i < 7; i++)
            if (bit_idx == 3'(i)) sh[i] <= bus.dio_in;
        end
      end
      if (mode_ld) fixed <= byte_val[2];
      if (snap_ld) snap  <= key_in;
      if (addr_ld)
        addr <= byte_val[AW-1:0];
      else if (ram_we && !fixed)
        addr <= addr + AW'(1);
      if (ram_we) ram[addr] <= byte_val;
      if (ctrl_ld) begin
        disp_on    <= byte_val[3];
        brightness <= byte_val[2:0];
      end
    end
  end

`ifdef TM1638_RESP_ERR_EN
  logic [7:0] errs;
  always_ff @(posedge clk_400KHz or negedge rst) begin
    if (!rst)                           errs <= '0;
    else if (err_evt && errs != 8'hFF)  errs <= errs + 8'd1;
  end
  assign err_cnt = errs;
`else
  logic unused_err;
  assign unused_err = err_evt;
  assign err_cnt    = '0;
`endif
endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: table of frames with expected RAM/control/error state, plus key-read, abort and reset sequences.
`timescale 1ns/1ps
module tb_tm1638_responder;
`ifdef TM1638_RESP_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic         clk_400KHz = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  key_in = '0;
  logic [127:0] disp_ram;
  logic         disp_on;
  logic [2:0]   brightness;
  logic         frame_done;
  logic [7:0]   err_cnt;
  logic         drv_dio = 1'b1;

  int npass = 0, ntot = 0, fd_cnt = 0, exp_fd = 0, exp_err = 0;

  tm1638_responder_if bus();
  assign bus.dio_in = bus.dio_oe ? bus.dio_out : drv_dio;

  tm1638_responder dut (
    .clk_400KHz (clk_400KHz),
    .rst        (rst),
    .bus        (bus),
    .key_in     (key_in),
    .disp_ram   (disp_ram),
    .disp_on    (disp_on),
    .brightness (brightness),
    .frame_done (frame_done),
    .err_cnt    (err_cnt)
  );

  always #1250 clk_400KHz = ~clk_400KHz;
  always @(negedge clk_400KHz) if (frame_done) fd_cnt++;

  typedef struct {
    logic [31:0] frm;
    int          n;
    int          ia;
    logic [7:0]  ea;
    int          ib;
    logic [7:0]  eb;
    logic        on;
    logic [2:0]  br;
    int          err;
  } vec_t;
  vec_t tv[13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic put(input logic s, input logic d);
    @(negedge clk_400KHz);
    bus.stb_in = s;
    drv_dio    = d;
  endtask

  task automatic send_bits(input logic [31:0] frm, input int nbits);
    for (int i = 0; i < nbits; i++) put(1'b0, frm[i]);
  endtask

  task automatic send_frame(input logic [31:0] frm, input int n);
    send_bits(frm, 8*n);
    repeat (3) put(1'b1, 1'b1);
  endtask

  function automatic logic [7:0] ram_at(input int idx);
    return disp_ram[8*idx +: 8];
  endfunction

  initial begin
    logic [31:0] rd;
    int          oe_bad;

    tv[0]  = '{32'h40,       1,  0, 8'h00, 15, 8'h00, 1'b0, 3'd0, 0};
    tv[1]  = '{32'h5B063FC0, 4,  0, 8'h3F,  2, 8'h5B, 1'b0, 3'd0, 0};
    tv[2]  = '{32'h44,       1,  1, 8'h06,  2, 8'h5B, 1'b0, 3'd0, 0};
    tv[3]  = '{32'h2211CE,   3, 14, 8'h22, 15, 8'h00, 1'b0, 3'd0, 0};
    tv[4]  = '{32'h40,       1,  0, 8'h3F, 13, 8'h00, 1'b0, 3'd0, 0};
    tv[5]  = '{32'h0B0ACF,   3, 15, 8'h0A,  0, 8'h0B, 1'b0, 3'd0, 0};
    tv[6]  = '{32'h8C,       1, 14, 8'h22,  3, 8'h00, 1'b1, 3'd4, 0};
    tv[7]  = '{32'h80,       1,  1, 8'h06,  2, 8'h5B, 1'b0, 3'd0, 0};
    tv[8]  = '{32'h41,       1, 14, 8'h22, 15, 8'h0A, 1'b0, 3'd0, 1};
    tv[9]  = '{32'h00,       1,  0, 8'h0B,  1, 8'h06, 1'b0, 3'd0, 2};
    tv[10] = '{32'h558B,     2,  0, 8'h0B,  3, 8'h00, 1'b1, 3'd3, 3};
    tv[11] = '{32'h77C3,     2,  3, 8'h77,  4, 8'h00, 1'b1, 3'd3, 3};
    tv[12] = '{32'h4F,       1,  3, 8'h77,  2, 8'h5B, 1'b1, 3'd3, 4};

    bus.stb_in = 1'b1;
    repeat (3) @(negedge clk_400KHz);
    check("rst_oe",    bus.dio_oe,  0);
    check("rst_out",   bus.dio_out, 1);
    check("rst_ram",   disp_ram,    0);
    check("rst_on",    disp_on,     0);
    check("rst_br",    brightness,  0);
    check("rst_done",  frame_done,  0);
    check("rst_err",   err_cnt,     0);
    rst = 1'b1;
    repeat (2) @(negedge clk_400KHz);

    for (int v = 0; v < 13; v++) begin
      send_frame(tv[v].frm, tv[v].n);
      exp_fd++;
      check($sformatf("v%0d_ram%0d", v, tv[v].ia), ram_at(tv[v].ia), tv[v].ea);
      check($sformatf("v%0d_ram%0d", v, tv[v].ib), ram_at(tv[v].ib), tv[v].eb);
      check($sformatf("v%0d_on", v),   disp_on,    tv[v].on);
      check($sformatf("v%0d_br", v),   brightness, tv[v].br);
      check($sformatf("v%0d_err", v),  err_cnt,    ERR_ON ? tv[v].err : 0);
      check($sformatf("v%0d_done", v), fd_cnt,     exp_fd);
    end
    exp_err = 4;

    // Key read: turnaround edge, then 32 bits LSB first from the snapshot.
    key_in = 32'h00A50301;
    send_bits(32'h42, 8);
    @(negedge clk_400KHz);
    check("key_oe_e8", bus.dio_oe, 0);
    key_in  = 32'hFFFFFFFF;
    drv_dio = 1'b1;
    @(negedge clk_400KHz);
    check("key_oe_turn", bus.dio_oe, 0);
    rd = '0;
    oe_bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_400KHz);
      if (!bus.dio_oe) oe_bad++;
      rd[k] = bus.dio_out;
      if (k == 31) bus.stb_in = 1'b1;
    end
    check("key_oe_bits", oe_bad, 0);
    check("key_data",    rd,     32'h00A50301);
    @(negedge clk_400KHz);
    check("key_oe_end", bus.dio_oe, 0);
    repeat (2) @(negedge clk_400KHz);
    exp_fd++;
    check("key_done", fd_cnt,  exp_fd);
    check("key_err",  err_cnt, ERR_ON ? exp_err : 0);

    // Partial data byte: no write, counts as a protocol error.
    send_bits(32'h99C0, 13);
    put(1'b1, 1'b1);
    @(negedge clk_400KHz);
    check("part_oe", bus.dio_oe, 0);
    repeat (2) @(negedge clk_400KHz);
    exp_err++;
    exp_fd++;
    check("part_ram0", ram_at(0), 8'h0B);
    check("part_err",  err_cnt,   ERR_ON ? exp_err : 0);
    check("part_done", fd_cnt,    exp_fd);

    // Abort mid key transmit: drive released on the very edge STB rises.
    key_in = 32'h5;
    send_bits(32'h42, 8);
    repeat (6) put(1'b0, 1'b1);
    @(negedge clk_400KHz);
    check("abort_oe_mid", bus.dio_oe, 1);
    bus.stb_in = 1'b1;
    @(negedge clk_400KHz);
    check("abort_oe_rel", bus.dio_oe, 0);
    repeat (2) @(negedge clk_400KHz);
    exp_fd++;
    check("abort_err",  err_cnt, ERR_ON ? exp_err : 0);
    check("abort_done", fd_cnt,  exp_fd);

    // Reset mid-WDATA after selecting fixed mode; reset must restore auto-increment.
    send_frame(32'h44, 1);
    exp_fd++;
    send_bits(32'hAAC5, 11);
    @(negedge clk_400KHz);
    rst = 1'b0;
    #10;
    check("mrst_ram",  disp_ram,    0);
    check("mrst_on",   disp_on,     0);
    check("mrst_br",   brightness,  0);
    check("mrst_oe",   bus.dio_oe,  0);
    check("mrst_out",  bus.dio_out, 1);
    check("mrst_err",  err_cnt,     0);
    exp_err = 0;
    bus.stb_in = 1'b1;
    @(negedge clk_400KHz);
    rst = 1'b1;
    @(negedge clk_400KHz);
    send_frame(32'h8877C3, 3);
    exp_fd++;
    check("post_ram3", ram_at(3), 8'h77);
    check("post_ram4", ram_at(4), 8'h88);
    check("post_done", fd_cnt,    exp_fd);
    check("post_err",  err_cnt,   0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
